// File: rtl/mmio_hex_led_port_if.sv
// Processor-side register bus for mmio_hex_led_port.
// master: processor/bus side drives address, data and strobes.
// slave : the port block returns registered read data.
interface mmio_hex_led_port_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              w;
    logic              r;
    logic [DATA_W-1:0] rd_data;

    modport master (output addr, output wr_data, output w, output r, input rd_data);
    modport slave  (input addr, input wr_data, input w, input r, output rd_data);
endinterface

// File: rtl/mmio_hex_led_port.sv
// mmio_hex_led_port: memory-mapped seven-segment / LED / switch port.
// Address map: 0..NUM_HEX-1 digit registers, NUM_HEX LED, NUM_HEX+1 switch
// status {chg, zeros, sw_sync} (read-only), NUM_HEX+2 blank mask.
// Optional feature macro: HEX_DECODE_EN -- digit registers hold a 4-bit nibble
// shown as a hex glyph; otherwise they hold raw segment bits (1 = segment on).
module mmio_hex_led_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_HEX = 6,
    parameter int LED_W   = 10,
    parameter int SW_W    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_hex_led_port_if.slave     bus,
    input  logic [SW_W-1:0]        sw,
    output logic [7*NUM_HEX-1:0]   hex_bus,
    output logic [LED_W-1:0]       ledr
);

`ifdef HEX_DECODE_EN
    localparam int HEX_W = 4;
`else
    localparam int HEX_W = 7;
`endif

    localparam logic [ADDR_W-1:0] LED_ADDR   = ADDR_W'(NUM_HEX);
    localparam logic [ADDR_W-1:0] SW_ADDR    = ADDR_W'(NUM_HEX + 1);
    localparam logic [ADDR_W-1:0] BLANK_ADDR = ADDR_W'(NUM_HEX + 2);

    logic [HEX_W-1:0]   hex_reg [NUM_HEX];
    logic [LED_W-1:0]   led_reg;
    logic [NUM_HEX-1:0] blank_reg;
    logic [SW_W-1:0]    sw_meta;
    logic [SW_W-1:0]    sw_sync;
    logic [SW_W-1:0]    sw_prev;
    logic               chg;
    logic [DATA_W-1:0]  rd_next;

    // Digit register contents to active-low segment pattern.
    function automatic logic [6:0] seg_of(input logic [HEX_W-1:0] v);
`ifdef HEX_DECODE_EN
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
`else
        return ~v;
`endif
    endfunction

    // Writable registers; writes to the status and unmapped addresses fall through.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_HEX; k++) hex_reg[k] <= '0;
            led_reg   <= '0;
            blank_reg <= '1;
        end else if (bus.w) begin
            for (int k = 0; k < NUM_HEX; k++)
                if (bus.addr == ADDR_W'(k)) hex_reg[k] <= bus.wr_data[HEX_W-1:0];
            if (bus.addr == LED_ADDR)   led_reg   <= bus.wr_data[LED_W-1:0];
            if (bus.addr == BLANK_ADDR) blank_reg <= bus.wr_data[NUM_HEX-1:0];
        end
    end

    // Switch synchroniser and sticky change flag; a new change beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
            chg     <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev)
                chg <= 1'b1;
            else if (bus.r && (bus.addr == SW_ADDR))
                chg <= 1'b0;
        end
    end

    // Read-data select from the current (pre-write) register values.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_HEX; k++)
            if (bus.addr == ADDR_W'(k)) rd_next = DATA_W'(hex_reg[k]);
        if (bus.addr == LED_ADDR) rd_next = DATA_W'(led_reg);
        if (bus.addr == SW_ADDR) begin
            rd_next = DATA_W'(sw_sync);
            rd_next[DATA_W-1] = chg;
        end
        if (bus.addr == BLANK_ADDR) rd_next = DATA_W'(blank_reg);
    end

    // Registered read data, one cycle after the address.
    always_ff @(posedge clk) begin
        if (reset) bus.rd_data <= '0;
        else       bus.rd_data <= rd_next;
    end

    // Registered board outputs, one edge behind the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_bus <= '1;
            ledr    <= '0;
        end else begin
            for (int k = 0; k < NUM_HEX; k++)
                hex_bus[7*k +: 7] <= blank_reg[k] ? 7'h7F : seg_of(hex_reg[k]);
            ledr <= led_reg;
        end
    end

endmodule

// File: tb/tb_mmio_hex_led_port.sv
// Directed bench for mmio_hex_led_port (default parameters).
module tb_mmio_hex_led_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sw;
    logic [41:0] hex_bus;
    logic [9:0]  ledr;
    int          checks = 0;
    int          failures = 0;

    mmio_hex_led_port_if #(.ADDR_W(4), .DATA_W(16)) bus_if ();

    mmio_hex_led_port #(
        .DATA_W(16), .ADDR_W(4), .NUM_HEX(6), .LED_W(10), .SW_W(10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .sw      (sw),
        .hex_bus (hex_bus),
        .ledr    (ledr)
    );

    always #5 clk = ~clk;

`ifdef HEX_DECODE_EN
    localparam logic [15:0] D0_WR   = 16'h0005;
    localparam logic [6:0]  D0_SEG  = 7'h12;
    localparam logic [6:0]  D1_SEG  = 7'h40;
    localparam logic [15:0] H2_READ = 16'h0005;
`else
    localparam logic [15:0] D0_WR   = 16'h003F;
    localparam logic [6:0]  D0_SEG  = 7'h40;
    localparam logic [6:0]  D1_SEG  = 7'h7F;
    localparam logic [15:0] H2_READ = 16'h0055;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sw = '0;
        bus_if.addr = '0;
        bus_if.wr_data = '0;
        bus_if.w = 1'b0;
        bus_if.r = 1'b0;
        step();
        step();
        check("reset_hex_bus", 64'(hex_bus), 64'h3FF_FFFF_FFFF);
        check("reset_ledr", 64'(ledr), 64'h0);
        check("reset_rd_data", 64'(bus_if.rd_data), 64'h0);

        // 1. blank mask reads all ones after reset
        reset = 1'b0;
        bus_if.addr = 4'd8;
        step();
        check("blank_reset_read", 64'(bus_if.rd_data), 64'h003F);

        // 2. LED write shows two edges later; digit 0 shows after blank cleared
        bus_if.addr = 4'd6; bus_if.wr_data = 16'h0003; bus_if.w = 1'b1;
        step();
        bus_if.w = 1'b0;
        check("ledr_one_edge", 64'(ledr), 64'h000);
        step();
        check("ledr_two_edges", 64'(ledr), 64'h003);
        bus_if.addr = 4'd8; bus_if.wr_data = 16'h0000; bus_if.w = 1'b1;
        step();
        bus_if.addr = 4'd0; bus_if.wr_data = D0_WR;
        step();
        bus_if.w = 1'b0;
        step();
        check("digit0_seg", 64'(hex_bus[6:0]), 64'(D0_SEG));
        check("digit1_seg", 64'(hex_bus[13:7]), 64'(D1_SEG));
        bus_if.addr = 4'd8; bus_if.wr_data = 16'h0001; bus_if.w = 1'b1;
        step();
        bus_if.w = 1'b0;
        step();
        check("digit0_blanked", 64'(hex_bus[6:0]), 64'h7F);

        // 3. switch change seen with CHG, consuming read clears it
        bus_if.addr = 4'd7; bus_if.r = 1'b0;
        sw = 10'h2A0;
        step(); step(); step(); step();
        check("sw_chg_set", 64'(bus_if.rd_data), 64'h82A0);
        bus_if.r = 1'b1;
        step();
        bus_if.r = 1'b0;
        check("sw_read_with_r", 64'(bus_if.rd_data), 64'h82A0);
        step();
        check("sw_chg_cleared", 64'(bus_if.rd_data), 64'h02A0);

        // 4. clear coincides with a newly detected change: change wins
        sw = 10'h155;
        step(); step();
        bus_if.r = 1'b1;
        step();
        bus_if.r = 1'b0;
        step();
        check("chg_beats_clear", 64'(bus_if.rd_data), 64'h8155);
        step();
        check("chg_still_set", 64'(bus_if.rd_data), 64'h8155);

        // 5. same-cycle write and read returns old value
        bus_if.addr = 4'd2; bus_if.wr_data = 16'h0055; bus_if.w = 1'b1;
        step();
        bus_if.w = 1'b0;
        check("rw_same_cycle_old", 64'(bus_if.rd_data), 64'h0000);
        step();
        check("rw_next_read_new", 64'(bus_if.rd_data), 64'(H2_READ));

        // 6. unmapped write ignored, then reset during a write
        bus_if.addr = 4'd12; bus_if.wr_data = 16'hFFFF; bus_if.w = 1'b1;
        step();
        bus_if.w = 1'b0;
        step();
        check("unmapped_read", 64'(bus_if.rd_data), 64'h0000);
        bus_if.addr = 4'd6;
        step();
        check("led_unchanged", 64'(bus_if.rd_data), 64'h0003);
        check("ledr_unchanged", 64'(ledr), 64'h003);
        bus_if.addr = 4'd8;
        step();
        check("blank_unchanged", 64'(bus_if.rd_data), 64'h0001);
        bus_if.addr = 4'd6; bus_if.wr_data = 16'h03FF; bus_if.w = 1'b1;
        reset = 1'b1;
        step();
        check("rst_write_ledr", 64'(ledr), 64'h000);
        check("rst_write_hex_bus", 64'(hex_bus), 64'h3FF_FFFF_FFFF);
        check("rst_write_rd_data", 64'(bus_if.rd_data), 64'h0);
        reset = 1'b0; bus_if.w = 1'b0;
        step();
        check("rst_led_reg", 64'(bus_if.rd_data), 64'h0000);
        bus_if.addr = 4'd8;
        step();
        check("rst_blank_reg", 64'(bus_if.rd_data), 64'h003F);
        bus_if.addr = 4'd2;
        step();
        check("rst_hex2_reg", 64'(bus_if.rd_data), 64'h0000);
        bus_if.addr = 4'd0;
        step();
        check("rst_hex0_reg", 64'(bus_if.rd_data), 64'h0000);
        step();
        check("ledr_after_rst", 64'(ledr), 64'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
